// File: rtl/beat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : beat_sequencer
//  Purpose  : 16-step / 4-track pattern playback controller. Gates the tempo
//             generator, advances on beat_tick pulses, emits fixed-length
//             note gates and a bar-start marker.
//  Revision : 1.0 - initial release
// ============================================================================
module beat_sequencer #(
   parameter int STEPS       = 16,
   parameter int TRACKS      = 4,
   parameter int GATE_CYCLES = 2_500_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       beat_tick_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic [$clog2(STEPS)-1:0]   loop_len_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(STEPS)-1:0]   wr_step_i,
   input  logic [TRACKS-1:0]          wr_data_i,
   output logic                       play_en_o,
   output logic [$clog2(STEPS)-1:0]   step_o,
   output logic [TRACKS-1:0]          gate_o,
   output logic                       bar_start_o,
   output logic [1:0]                 state_o
);

   localparam int SW = $clog2(STEPS);
   localparam int CW = $clog2(GATE_CYCLES + 1);
   localparam logic [CW-1:0] c_GATE_LOAD = CW'(GATE_CYCLES);

   localparam logic [1:0] c_IDLE    = 2'b00;
   localparam logic [1:0] c_ARMED   = 2'b01;
   localparam logic [1:0] c_PLAYING = 2'b10;
   localparam logic [1:0] c_DRAIN   = 2'b11;

   logic [TRACKS-1:0] pattern_q [STEPS];

   logic [1:0]        state_q,   state_d;
   logic [SW-1:0]     step_q,    step_d;
   logic [SW-1:0]     loop_q,    loop_d;
   logic [TRACKS-1:0] gate_q,    gate_d;
   logic [CW-1:0]     cnt_q,     cnt_d;
   logic              bar_q,     bar_d;
   logic              play_en_q, play_en_d;

   logic              w_fire;
   logic [SW-1:0]     w_fire_step;
   logic [TRACKS-1:0] w_fire_data;

   // Pattern memory: writable in any state, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < STEPS; i++) begin
            pattern_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         pattern_q[wr_step_i] <= wr_data_i;
      end
   end

   // Next-state: playback FSM, step advance, gate timing and step fire.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      loop_d      = loop_q;
      gate_d      = gate_q;
      cnt_d       = cnt_q;
      bar_d       = 1'b0;
      play_en_d   = play_en_q;
      w_fire      = 1'b0;
      w_fire_step = '0;
      w_fire_data = '0;

      // Gate countdown; gates drop on the edge where the count hits zero.
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            gate_d = '0;
         end
      end

      case (state_q)
         c_IDLE: begin
            step_d    = '0;
            gate_d    = '0;
            cnt_d     = '0;
            play_en_d = 1'b0;
            if (start_i && !stop_i) begin
               state_d   = c_ARMED;
               loop_d    = loop_len_i;
               play_en_d = 1'b1;
            end
         end
         c_ARMED: begin
            if (stop_i) begin
               state_d   = c_IDLE;
               play_en_d = 1'b0;
            end else if (beat_tick_i) begin
               state_d     = c_PLAYING;
               w_fire      = 1'b1;
               w_fire_step = '0;
            end
         end
         c_PLAYING: begin
            if (stop_i) begin
               state_d   = c_DRAIN;
               play_en_d = 1'b0;
            end else if (beat_tick_i) begin
               w_fire = 1'b1;
               if (step_q == loop_q) begin
                  // Wrap: a new loop length only takes effect at bar start.
                  w_fire_step = '0;
                  loop_d      = loop_len_i;
               end else begin
                  w_fire_step = step_q + 1'b1;
               end
            end
         end
         default: begin
            // DRAIN: ticks ignored, wait for the running gate to expire.
            if (cnt_q == '0) begin
               state_d = c_IDLE;
               step_d  = '0;
            end
         end
      endcase

      if (w_fire) begin
         // A write to the firing step in the same cycle wins over the stored row.
         if (wr_en_i && (wr_step_i == w_fire_step)) begin
            w_fire_data = wr_data_i;
         end else begin
            w_fire_data = pattern_q[w_fire_step];
         end
         step_d = w_fire_step;
         gate_d = w_fire_data;
         cnt_d  = c_GATE_LOAD;
         bar_d  = (w_fire_step == '0);
      end
   end

   // Registered state and outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= c_IDLE;
         step_q    <= '0;
         loop_q    <= '0;
         gate_q    <= '0;
         cnt_q     <= '0;
         bar_q     <= 1'b0;
         play_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         loop_q    <= loop_d;
         gate_q    <= gate_d;
         cnt_q     <= cnt_d;
         bar_q     <= bar_d;
         play_en_q <= play_en_d;
      end
   end

   assign play_en_o   = play_en_q;
   assign step_o      = step_q;
   assign gate_o      = gate_q;
   assign bar_start_o = bar_q;
   assign state_o     = state_q;

endmodule
`default_nettype wire
